// File: rtl/padded_pixel_streamer.sv
// Streams one feature-map frame to the window generator, wrapping the interior
// beats from upstream with PAD rings of zero beats; one issued beat per cycle max.
module padded_pixel_streamer #(
   parameter int PAD    = 1,
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [31:0]       img_width,
   input  logic [31:0]       img_height,
   input  logic [31:0]       in_channels,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic              m_ready,
   output logic [DATA_W-1:0] pixel_out,
   output logic              data_valid,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   localparam logic [32:0] PAD_V  = 33'(PAD);
   localparam logic [32:0] PAD_X2 = 33'(2 * PAD);

   state_t      state;
   logic [31:0] w_r;
   logic [31:0] h_r;
   logic [31:0] c_r;
   logic [31:0] beat;
   logic [31:0] col;
   logic [31:0] row;

   logic [32:0] col_last;
   logic [32:0] row_last;
   logic [31:0] beat_last;
   logic        beat_end;
   logic        col_end;
   logic        row_end;
   logic        border;
   logic        running;
   logic        issue;
   logic        zero_cfg;

   // Padded extents are 33 bits so W+2*PAD cannot wrap for legal configs.
   assign col_last  = {1'b0, w_r} + PAD_X2 - 33'd1;
   assign row_last  = {1'b0, h_r} + PAD_X2 - 33'd1;
   assign beat_last = c_r - 32'd1;

   assign beat_end = (beat == beat_last);
   assign col_end  = ({1'b0, col} == col_last);
   assign row_end  = ({1'b0, row} == row_last);

   assign border = (PAD != 0) &&
                   ((row == 32'd0) || ({1'b0, row} == {1'b0, h_r} + PAD_V) ||
                    (col == 32'd0) || ({1'b0, col} == {1'b0, w_r} + PAD_V));

   assign running  = (state == S_RUN);
   assign issue    = running && m_ready && (border || s_valid);
   assign s_ready  = running && !border && m_ready;
   assign busy     = (state != S_IDLE);
   assign zero_cfg = (img_width == 32'd0) || (img_height == 32'd0) ||
                     (in_channels == 32'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         w_r        <= '0;
         h_r        <= '0;
         c_r        <= '0;
         beat       <= '0;
         col        <= '0;
         row        <= '0;
         pixel_out  <= '0;
         data_valid <= 1'b0;
         done       <= 1'b0;
      end else begin
         done       <= 1'b0;
         data_valid <= issue;
         if (issue) begin
            pixel_out <= border ? '0 : s_data;
         end

         case (state)
            S_IDLE: begin
               if (start) begin
                  w_r   <= img_width;
                  h_r   <= img_height;
                  c_r   <= in_channels;
                  beat  <= '0;
                  col   <= '0;
                  row   <= '0;
                  state <= zero_cfg ? S_DONE : S_RUN;
               end
            end
            S_RUN: begin
               if (issue) begin
                  // The final beat leaves the counters parked on their last values.
                  if (beat_end && col_end && row_end) begin
                     state <= S_DONE;
                  end else if (!beat_end) begin
                     beat <= beat + 32'd1;
                  end else begin
                     beat <= '0;
                     if (col_end) begin
                        col <= '0;
                        row <= row + 32'd1;
                     end else begin
                        col <= col + 32'd1;
                     end
                  end
               end
            end
            S_DONE: begin
               done  <= 1'b1;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_padded_pixel_streamer.sv
// Directed bench: a PAD=1 and a PAD=0 instance share stimulus; a vector table
// drives whole frames, hand sequences cover empty config and mid-frame reset.
module tb_padded_pixel_streamer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        sel;
   logic [31:0] img_width;
   logic [31:0] img_height;
   logic [31:0] in_channels;
   logic [63:0] s_data;
   logic        s_valid;
   logic        m_ready;

   logic        start1, start0;
   logic        sr1, sr0, dv1, dv0, bsy1, bsy0, dn1, dn0;
   logic [63:0] pix1, pix0;
   logic        sr, dv, bsy, dn;
   logic [63:0] pix;

   always #5 clk = ~clk;

   assign start1 = start & ~sel;
   assign start0 = start & sel;
   assign sr  = sel ? sr0  : sr1;
   assign dv  = sel ? dv0  : dv1;
   assign bsy = sel ? bsy0 : bsy1;
   assign dn  = sel ? dn0  : dn1;
   assign pix = sel ? pix0 : pix1;

   padded_pixel_streamer #(.PAD(1), .DATA_W(64)) u_pad1 (
      .clk(clk), .rst(rst), .start(start1),
      .img_width(img_width), .img_height(img_height), .in_channels(in_channels),
      .s_data(s_data), .s_valid(s_valid), .s_ready(sr1), .m_ready(m_ready),
      .pixel_out(pix1), .data_valid(dv1), .busy(bsy1), .done(dn1)
   );

   padded_pixel_streamer #(.PAD(0), .DATA_W(64)) u_pad0 (
      .clk(clk), .rst(rst), .start(start0),
      .img_width(img_width), .img_height(img_height), .in_channels(in_channels),
      .s_data(s_data), .s_valid(s_valid), .s_ready(sr0), .m_ready(m_ready),
      .pixel_out(pix0), .data_valid(dv0), .busy(bsy0), .done(dn0)
   );

   // mode: 0 free-running, 1 s_valid stalled 3 cycles at first interior beat,
   // 2 m_ready toggling 1,0,1,0...
   typedef struct packed {
      logic         sel;
      logic [7:0]   w;
      logic [7:0]   h;
      logic [7:0]   c;
      logic [1:0]   mode;
      logic         mid_start;
      logic [4:0]   n_beats;
      logic [3:0]   n_src;
      logic [2:0]   exp_gap;
      logic [63:0]  src;
      logic [127:0] seq;
   } vec_t;

   vec_t vecs [5];
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic s, input logic [7:0] w, input logic [7:0] h,
                               input logic [7:0] c, input logic [1:0] mode, input logic mid,
                               input logic [4:0] nb, input logic [3:0] ns,
                               input logic [2:0] gap, input logic [63:0] src,
                               input logic [127:0] seq);
      vec_t v;
      v.sel = s; v.w = w; v.h = h; v.c = c; v.mode = mode; v.mid_start = mid;
      v.n_beats = nb; v.n_src = ns; v.exp_gap = gap; v.src = src; v.seq = seq;
      return v;
   endfunction

   task automatic run_vec(input vec_t v, input string tag);
      int  idx = 0, src_i = 0, stall = 3, cyc = 0;
      int  last_cyc = -1, done_cyc = -1, max_gap = 0, cur_gap = 0;
      int  sr_hi = 0, sr_bad = 0;
      bit  hs, seen_first = 0, seen_done = 0, stall_now;
      logic [7:0] exp_b;
      sel = v.sel;
      @(negedge clk);
      img_width = 32'(v.w); img_height = 32'(v.h); in_channels = 32'(v.c);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (!seen_done && cyc < 300) begin
         if (dv) begin
            if (seen_first && cur_gap > max_gap) max_gap = cur_gap;
            if (idx < int'(v.n_beats)) begin
               exp_b = v.seq[(15 - idx) * 8 +: 8];
               chk({tag, " beat"}, pix, {56'd0, exp_b});
            end
            idx++;
            last_cyc   = cyc;
            cur_gap    = 0;
            seen_first = 1;
         end else if (seen_first) begin
            cur_gap++;
         end
         if (dn) begin
            done_cyc  = cyc;
            seen_done = 1;
         end
         m_ready = (v.mode == 2'd2) ? (cyc % 2 == 0) : 1'b1;
         if (v.mid_start && cyc == 6) begin
            img_width = 32'd0;
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         #1;
         if (!m_ready && sr) sr_bad++;
         if (sr) sr_hi++;
         stall_now = (v.mode == 2'd1) && (stall > 0) && sr;
         if (stall_now) stall--;
         s_valid = (src_i < int'(v.n_src)) && !stall_now;
         s_data  = (src_i < int'(v.n_src)) ? {56'd0, v.src[(7 - src_i) * 8 +: 8]} : 64'd0;
         hs = s_valid && sr;
         @(posedge clk);
         if (hs) src_i++;
         @(negedge clk);
         cyc++;
      end
      start   = 1'b0;
      s_valid = 1'b0;
      chk({tag, " beat count"}, 64'(idx), 64'(v.n_beats));
      chk({tag, " consumed"}, 64'(src_i), 64'(v.n_src));
      chk({tag, " done after last beat"}, 64'(done_cyc - last_cyc), 64'd1);
      chk({tag, " max gap"}, 64'(max_gap), 64'(v.exp_gap));
      chk({tag, " s_ready while m_ready low"}, 64'(sr_bad), 64'd0);
      if (v.mode == 2'd0) chk({tag, " s_ready cycles"}, 64'(sr_hi), 64'(v.n_src));
      chk({tag, " done one cycle"}, {63'd0, dn}, 64'd0);
      chk({tag, " idle after done"}, {63'd0, bsy}, 64'd0);
   endtask

   initial begin
      int bc, dvc, dnc, dpos, beats, t;
      vecs[0] = mk(0, 2, 2, 1, 2'd0, 0, 16, 4, 0, 64'h0A0B0C0D_00000000,
                   128'h00000000_000A0B00_000C0D00_00000000);
      vecs[1] = mk(0, 2, 2, 1, 2'd1, 0, 16, 4, 3, 64'h0A0B0C0D_00000000,
                   128'h00000000_000A0B00_000C0D00_00000000);
      vecs[2] = mk(0, 2, 2, 1, 2'd2, 0, 16, 4, 1, 64'h0A0B0C0D_00000000,
                   128'h00000000_000A0B00_000C0D00_00000000);
      vecs[3] = mk(1, 3, 1, 2, 2'd0, 0, 6, 6, 0, 64'h01020304_05060000,
                   128'h01020304_05060000_00000000_00000000);
      vecs[4] = mk(0, 2, 2, 1, 2'd0, 1, 16, 4, 0, 64'h0A0B0C0D_00000000,
                   128'h00000000_000A0B00_000C0D00_00000000);

      rst = 1'b1; start = 1'b0; sel = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
      s_data = '0; img_width = '0; img_height = '0; in_channels = '0;
      repeat (2) @(negedge clk);
      chk("reset s_ready", {63'd0, sr1}, 64'd0);
      chk("reset data_valid", {63'd0, dv1}, 64'd0);
      chk("reset pixel_out", pix1, 64'd0);
      chk("reset busy", {63'd0, bsy1}, 64'd0);
      chk("reset done", {63'd0, dn1}, 64'd0);
      chk("reset pad0 s_ready", {63'd0, sr0}, 64'd0);
      rst = 1'b0;

      for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Empty frame: straight to DONE, no beats.
      sel = 1'b0;
      @(negedge clk);
      img_width = 32'd0; img_height = 32'd2; in_channels = 32'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      bc = 0; dvc = 0; dnc = 0; dpos = -1;
      for (int k = 1; k <= 5; k++) begin
         if (bsy) bc++;
         if (dv) dvc++;
         if (dn) dnc++;
         if (dn && dpos < 0) dpos = k;
         @(negedge clk);
      end
      chk("zero cfg busy cycles", 64'(bc), 64'd1);
      chk("zero cfg data_valid", 64'(dvc), 64'd0);
      chk("zero cfg done position", 64'(dpos), 64'd2);
      chk("zero cfg done width", 64'(dnc), 64'd1);

      // Reset after five issued beats, then a clean frame with a stray start.
      img_width = 32'd2; img_height = 32'd2; in_channels = 32'd1; start = 1'b1;
      m_ready = 1'b1; s_valid = 1'b1; s_data = 64'h0A;
      @(negedge clk);
      start = 1'b0;
      beats = 0; t = 0;
      while (beats < 5 && t < 100) begin
         if (dv) beats++;
         if (beats < 5) @(negedge clk);
         t++;
      end
      chk("beats before reset", 64'(beats), 64'd5);
      rst = 1'b1;
      @(negedge clk);
      chk("mid reset data_valid", {63'd0, dv}, 64'd0);
      chk("mid reset pixel_out", pix, 64'd0);
      chk("mid reset busy", {63'd0, bsy}, 64'd0);
      chk("mid reset done", {63'd0, dn}, 64'd0);
      chk("mid reset s_ready", {63'd0, sr}, 64'd0);
      rst = 1'b0; s_valid = 1'b0;
      run_vec(vecs[4], "after reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
